// File: rtl/tic_tac_toe_pkg.sv
// Shared types and constants for the tic-tac-toe turn scheduler.
package tic_tac_toe_pkg;

  typedef enum logic [2:0] {
    S_PLAYER,
    S_P_CHECK,
    S_COMPUTER,
    S_C_CHECK,
    S_OVER
  } state_e;

  localparam logic [1:0] TURN_PLAYER = 2'b01;
  localparam logic [1:0] TURN_PC     = 2'b10;
  localparam logic [1:0] TURN_NONE   = 2'b00;

  localparam logic [3:0] MAX_CELL = 4'd8;

endpackage

// File: rtl/tic_tac_toe_turn_scheduler_if.sv
// Button, board-detector and status signals between the scheduler and its environment.
interface tic_tac_toe_turn_scheduler_if #(
  parameter int unsigned SEC_W = 6
);
  logic             play;
  logic             pc;
  logic [3:0]       player_position;
  logic [3:0]       computer_position;
  logic             illegal_move;
  logic             win;
  logic             no_space;
  logic             player_play;
  logic             computer_play;
  logic [3:0]       move_position;
  logic [1:0]       turn;
  logic [SEC_W-1:0] seconds_left;
  logic             time_out;
  logic             illegal_flag;
  logic             game_over;

  modport master (
    output play, pc, player_position, computer_position, illegal_move, win, no_space,
    input  player_play, computer_play, move_position, turn, seconds_left, time_out,
           illegal_flag, game_over
  );

  modport slave (
    input  play, pc, player_position, computer_position, illegal_move, win, no_space,
    output player_play, computer_play, move_position, turn, seconds_left, time_out,
           illegal_flag, game_over
  );
endinterface

// File: rtl/turn_timer.sv
// Per-turn countdown: a CLK_HZ prescaler feeding a seconds down-counter that
// reloads itself after the last second expires.
module turn_timer #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned TURN_SECONDS = 30,
  parameter int unsigned SEC_W        = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             reload,
  output logic [SEC_W-1:0] seconds_left,
  output logic             expire
);
  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0]    presc_q;
  logic [SEC_W-1:0] sec_q;
  logic             tc;

  assign tc           = run && (presc_q == PW'(CLK_HZ - 1));
  assign expire       = tc && (sec_q == SEC_W'(1));
  assign seconds_left = sec_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      sec_q   <= SEC_W'(TURN_SECONDS);
    end else if (reload) begin
      presc_q <= '0;
      sec_q   <= SEC_W'(TURN_SECONDS);
    end else if (tc) begin
      presc_q <= '0;
      sec_q   <= expire ? SEC_W'(TURN_SECONDS) : sec_q - SEC_W'(1);
    end else if (run) begin
      presc_q <= presc_q + PW'(1);
    end
  end

endmodule

// File: rtl/tic_tac_toe_turn_scheduler.sv
// Turn sequencing between player and computer with commit strobes and a turn timer.
// Define TURN_TIMEOUT_EN to enable the per-turn countdown and timeout.
module tic_tac_toe_turn_scheduler
  import tic_tac_toe_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned TURN_SECONDS = 30,
  parameter int unsigned SEC_W        = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  tic_tac_toe_turn_scheduler_if.slave   io
);

  if (CLK_HZ < 1 || (64'd1 << SEC_W) <= 64'(TURN_SECONDS)) begin : g_bad_cfg
    $error("tic_tac_toe_turn_scheduler: invalid CLK_HZ/SEC_W/TURN_SECONDS");
  end

  state_e     state_q;
  logic [1:0] turn_q;
  logic       play_prev_q, pc_prev_q;
  logic       player_play_q, computer_play_q;
  logic [3:0] move_q;
  logic       time_out_q, illegal_q, game_over_q;
  logic       play_edge, pc_edge;
  logic       expire;

  assign play_edge = io.play && !play_prev_q;
  assign pc_edge   = io.pc && !pc_prev_q;

`ifdef TURN_TIMEOUT_EN
  logic timer_run, timer_reload;

  assign timer_run    = (state_q == S_PLAYER) || (state_q == S_COMPUTER);
  // Fresh countdown whenever a check state hands the turn to the opponent.
  assign timer_reload = ((state_q == S_P_CHECK) || (state_q == S_C_CHECK)) &&
                        !(io.win || io.no_space);

  turn_timer #(
    .CLK_HZ      (CLK_HZ),
    .TURN_SECONDS(TURN_SECONDS),
    .SEC_W       (SEC_W)
  ) u_turn_timer (
    .clock       (clock),
    .reset       (reset),
    .run         (timer_run),
    .reload      (timer_reload),
    .seconds_left(io.seconds_left),
    .expire      (expire)
  );
`else
  assign expire          = 1'b0;
  assign io.seconds_left = SEC_W'(TURN_SECONDS);
`endif

  // A pending strobe (verdict cycle) or a committing edge suppresses the timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_PLAYER;
      turn_q          <= TURN_PLAYER;
      play_prev_q     <= 1'b0;
      pc_prev_q       <= 1'b0;
      player_play_q   <= 1'b0;
      computer_play_q <= 1'b0;
      move_q          <= 4'd0;
      time_out_q      <= 1'b0;
      illegal_q       <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      play_prev_q     <= io.play;
      pc_prev_q       <= io.pc;
      player_play_q   <= 1'b0;
      computer_play_q <= 1'b0;
      time_out_q      <= 1'b0;
      illegal_q       <= 1'b0;
      unique case (state_q)
        S_PLAYER: begin
          if (player_play_q) begin
            if (io.illegal_move) illegal_q <= 1'b1;
            else                 state_q   <= S_P_CHECK;
          end else if (play_edge && io.player_position <= MAX_CELL) begin
            player_play_q <= 1'b1;
            move_q        <= io.player_position;
          end else begin
            if (play_edge) illegal_q <= 1'b1;
            if (expire) begin
              time_out_q <= 1'b1;
              state_q    <= S_COMPUTER;
              turn_q     <= TURN_PC;
            end
          end
        end
        S_COMPUTER: begin
          if (computer_play_q) begin
            if (io.illegal_move) illegal_q <= 1'b1;
            else                 state_q   <= S_C_CHECK;
          end else if (pc_edge && io.computer_position <= MAX_CELL) begin
            computer_play_q <= 1'b1;
            move_q          <= io.computer_position;
          end else begin
            if (pc_edge) illegal_q <= 1'b1;
            if (expire) begin
              time_out_q <= 1'b1;
              state_q    <= S_PLAYER;
              turn_q     <= TURN_PLAYER;
            end
          end
        end
        S_P_CHECK, S_C_CHECK: begin
          if (io.win || io.no_space) begin
            state_q     <= S_OVER;
            turn_q      <= TURN_NONE;
            game_over_q <= 1'b1;
          end else if (state_q == S_P_CHECK) begin
            state_q <= S_COMPUTER;
            turn_q  <= TURN_PC;
          end else begin
            state_q <= S_PLAYER;
            turn_q  <= TURN_PLAYER;
          end
        end
        S_OVER: begin
          game_over_q <= 1'b1;
        end
        default: begin
          state_q <= S_PLAYER;
          turn_q  <= TURN_PLAYER;
        end
      endcase
    end
  end

  assign io.player_play   = player_play_q;
  assign io.computer_play = computer_play_q;
  assign io.move_position = move_q;
  assign io.turn          = turn_q;
  assign io.time_out      = time_out_q;
  assign io.illegal_flag  = illegal_q;
  assign io.game_over     = game_over_q;

endmodule

// File: tb/tb_tic_tac_toe_turn_scheduler.sv
// Self-checking bench for tic_tac_toe_turn_scheduler against a cycle-level game model.
module tb_tic_tac_toe_turn_scheduler;
  localparam int CLK_HZ       = 4;
  localparam int TURN_SECONDS = 3;
  localparam int SEC_W        = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  tic_tac_toe_turn_scheduler_if #(.SEC_W(SEC_W)) bus ();

  tic_tac_toe_turn_scheduler #(
    .CLK_HZ      (CLK_HZ),
    .TURN_SECONDS(TURN_SECONDS),
    .SEC_W       (SEC_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (bus)
  );

  always #5 clock = ~clock;

  // Model: whose turn (1 player, 2 computer, 0 over), move phase
  // (0 waiting, 1 strobe awaiting verdict, 2 board check) and cycles used this turn.
  int         m_owner, m_phase, m_elapsed;
  logic       m_prev_play, m_prev_pc;
  logic       e_pp, e_cp, e_to, e_ill;
  logic [3:0] e_move;

  function automatic logic [16:0] exp_vec();
    logic [1:0] t;
    t = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    return {e_pp, e_cp, e_move, t, 6'(TURN_SECONDS - m_elapsed / CLK_HZ), e_to, e_ill,
            (m_owner == 0)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {bus.player_play, bus.computer_play, bus.move_position, bus.turn, bus.seconds_left,
            bus.time_out, bus.illegal_flag, bus.game_over};
  endfunction

  task automatic model_reset();
    m_owner = 1; m_phase = 0; m_elapsed = 0;
    m_prev_play = 0; m_prev_pc = 0;
    e_pp = 0; e_cp = 0; e_to = 0; e_ill = 0; e_move = 0;
  endtask

  task automatic model_step();
    logic ep, ec, myedge, commit, pend, expiring;
    logic [3:0] mypos;
    ep = bus.play && !m_prev_play;
    ec = bus.pc && !m_prev_pc;
    m_prev_play = bus.play;
    m_prev_pc   = bus.pc;
    e_pp = 0; e_cp = 0; e_to = 0; e_ill = 0;
    if (m_owner == 0) return;
    if (m_phase == 2) begin
      if (bus.win || bus.no_space) m_owner = 0;
      else begin
        m_owner = 3 - m_owner;
        m_elapsed = 0;
      end
      m_phase = 0;
      return;
    end
    expiring = 0;
`ifdef TURN_TIMEOUT_EN
    expiring  = (m_elapsed == TURN_SECONDS * CLK_HZ - 1);
    m_elapsed = expiring ? 0 : m_elapsed + 1;
`endif
    pend   = (m_phase == 1);
    myedge = (m_owner == 1) ? ep : ec;
    mypos  = (m_owner == 1) ? bus.player_position : bus.computer_position;
    commit = 0;
    if (pend) begin
      if (bus.illegal_move) begin
        e_ill = 1;
        m_phase = 0;
      end else m_phase = 2;
    end else if (myedge) begin
      if (mypos <= 4'd8) begin
        commit = 1;
        m_phase = 1;
        e_move = mypos;
        if (m_owner == 1) e_pp = 1; else e_cp = 1;
      end else e_ill = 1;
    end
    if (expiring && !pend && !commit) begin
      e_to = 1;
      m_owner = 3 - m_owner;
    end
  endtask

  // Drive inputs away from the edge, clock once, advance the model, sample 1ns later.
  task automatic cycle(input logic p, input logic c, input logic [3:0] pp, input logic [3:0] cp,
                       input logic ill, input logic w, input logic ns);
    bus.play = p; bus.pc = c; bus.player_position = pp; bus.computer_position = cp;
    bus.illegal_move = ill; bus.win = w; bus.no_space = ns;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic assert_reset();
    bus.play = 0; bus.pc = 0; bus.player_position = 0; bus.computer_position = 0;
    bus.illegal_move = 0; bus.win = 0; bus.no_space = 0;
    reset = 0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1;
  endtask

  task automatic test_reset();
    @(posedge clock); #2;
    assert_reset();
    if (dut_vec() !== 17'b0_0_0000_01_000011_0_0_0) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec(), 17'b0_0_0000_01_000011_0_0_0);
    end
    n_chk++;
    release_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
    end
    n_chk++;
  endtask

  task automatic test_legal_move();
    assert_reset(); release_reset();
    cycle(1, 0, 4'd4, 0, 0, 0, 0);
    if (bus.player_play !== 1'b1 || bus.move_position !== 4'd4) begin
      n_fail++; $display("FAIL legal_strobe: got pp=%b pos=%0d want pp=1 pos=4",
                         bus.player_play, bus.move_position);
    end
    n_chk++;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 4'd4, 0, 0, 0, 0);
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL legal_seq c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      n_chk++;
      if (i == 1 && (bus.turn !== 2'b10 || bus.seconds_left !== 6'd3)) begin
        n_fail++; $display("FAIL legal_turn: got turn=%b sec=%0d want turn=10 sec=3",
                           bus.turn, bus.seconds_left);
      end
      if (i == 1) n_chk++;
    end
  endtask

  task automatic test_illegal_move();
    assert_reset(); release_reset();
    cycle(1, 0, 4'd4, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 4'd4, 0, 1, 0, 0);
      if (i == 0 && bus.illegal_flag !== 1'b1) begin
        n_fail++; $display("FAIL illegal_flag: got %b want 1", bus.illegal_flag);
      end
      if (dut_vec() !== exp_vec() || bus.turn !== 2'b01) begin
        n_fail++; $display("FAIL illegal_seq c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      n_chk++;
    end
    cycle(0, 0, 4'd9, 0, 0, 0, 0);
    cycle(1, 0, 4'd9, 0, 0, 0, 0);
    if (bus.player_play !== 1'b0 || bus.illegal_flag !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL bad_cell: got %h want %h", dut_vec(), exp_vec());
    end
    n_chk++;
  endtask

  task automatic test_timeout();
    logic [1:0] want_turn;
`ifdef TURN_TIMEOUT_EN
    want_turn = 2'b10;
`else
    want_turn = 2'b01;
`endif
    assert_reset(); release_reset();
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL timeout_seq c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      n_chk++;
`ifdef TURN_TIMEOUT_EN
      if (i == 12 && bus.time_out !== 1'b1) begin
        n_fail++; $display("FAIL timeout_pulse: got %b want 1", bus.time_out);
      end
      if (i == 12) n_chk++;
`endif
    end
    if (bus.turn !== want_turn) begin
      n_fail++; $display("FAIL timeout_turn: got %b want %b", bus.turn, want_turn);
    end
    n_chk++;
  endtask

  task automatic test_expiry_edge();
    assert_reset(); release_reset();
    for (int i = 1; i <= 11; i++) cycle(0, i[0], 0, 4'd2, 0, 0, 0);
    cycle(1, 1, 4'd7, 4'd2, 0, 0, 0);
    if (bus.player_play !== 1'b1 || bus.time_out !== 1'b0 || bus.move_position !== 4'd7) begin
      n_fail++; $display("FAIL expiry_edge: got pp=%b to=%b pos=%0d want pp=1 to=0 pos=7",
                         bus.player_play, bus.time_out, bus.move_position);
    end
    n_chk++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL expiry_model: got %h want %h", dut_vec(), exp_vec());
    end
    n_chk++;
  endtask

  task automatic test_game_over();
    assert_reset(); release_reset();
    cycle(1, 0, 4'd0, 0, 0, 0, 0);
    cycle(0, 0, 4'd0, 0, 0, 0, 0);
    cycle(0, 0, 4'd0, 0, 0, 0, 0);
    cycle(0, 1, 0, 4'd5, 0, 0, 0);
    if (bus.computer_play !== 1'b1 || bus.move_position !== 4'd5) begin
      n_fail++; $display("FAIL pc_strobe: got cp=%b pos=%0d want cp=1 pos=5",
                         bus.computer_play, bus.move_position);
    end
    n_chk++;
    cycle(0, 1, 0, 4'd5, 0, 0, 0);
    cycle(0, 1, 0, 4'd5, 0, 1, 0);
    if (bus.turn !== 2'b00 || bus.game_over !== 1'b1) begin
      n_fail++; $display("FAIL game_over: got turn=%b go=%b want turn=00 go=1",
                         bus.turn, bus.game_over);
    end
    n_chk++;
    for (int i = 0; i < 10; i++) begin
      cycle(i[0], !i[0], 4'(i % 9), 4'(i % 9), 0, 0, 0);
      if (bus.player_play !== 1'b0 || bus.computer_play !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL over_frozen c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      n_chk++;
    end
  endtask

  task automatic test_reset_mid_computer();
    assert_reset(); release_reset();
    cycle(1, 0, 4'd3, 0, 0, 0, 0);
    cycle(0, 0, 4'd3, 0, 0, 0, 0);
    cycle(0, 0, 4'd3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    #2;
    assert_reset();
    if (dut_vec() !== 17'b0_0_0000_01_000011_0_0_0) begin
      n_fail++; $display("FAIL reset_mid_pc: got %h want %h", dut_vec(), 17'b0_0_0000_01_000011_0_0_0);
    end
    n_chk++;
    release_reset();
  endtask

  task automatic test_random();
    logic p, c, ill, w, ns;
    logic [3:0] pp, cp;
    int over_cycles;
    assert_reset(); release_reset();
    over_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      p   = ($urandom_range(0, 3) == 0);
      c   = ($urandom_range(0, 3) == 0);
      pp  = 4'($urandom_range(0, 10));
      cp  = 4'($urandom_range(0, 10));
      ill = ($urandom_range(0, 3) == 0);
      w   = ($urandom_range(0, 11) == 0);
      ns  = ($urandom_range(0, 15) == 0);
      if ((i / 100) % 2 == 1) begin
        p = 0;
        c = 0;
      end
      cycle(p, c, pp, cp, ill, w, ns);
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      n_chk++;
      if (bus.player_play === 1'b1 && bus.computer_play === 1'b1) begin
        n_fail++; $display("FAIL dual_strobe c%0d: got 11 want at most one", i);
      end
      n_chk++;
      over_cycles = (m_owner == 0) ? over_cycles + 1 : 0;
      if (over_cycles > 4) begin
        #2;
        assert_reset(); release_reset();
        over_cycles = 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.play = 0; bus.pc = 0; bus.player_position = 0; bus.computer_position = 0;
    bus.illegal_move = 0; bus.win = 0; bus.no_space = 0;
    model_reset();
    test_reset();
    test_legal_move();
    test_illegal_move();
    test_timeout();
    test_expiry_edge();
    test_game_over();
    test_reset_mid_computer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tic_tac_toe_turn_scheduler.md
Name: tic_tac_toe_turn_scheduler

Overview:
Sequences play between the human player and the computer on the shared board datapath (position registers, illegal-move, win and no-space detectors). Owns whose turn it is and edge-detects the play/pc buttons. Issues single-cycle player_play/computer_play commit strobes with the selected cell. Runs a per-turn countdown; on expiry the turn passes to the opponent.

Parameters:
CLK_HZ, 50000000, clock cycles per second (prescaler terminal count = CLK_HZ-1)
TURN_SECONDS, 30, seconds allowed per turn
SEC_W, 6, width of seconds_left; must satisfy 2^SEC_W > TURN_SECONDS

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
play  in  1  player button, level, already synchronised
pc  in  1  computer button, level, already synchronised
player_position  in  4  player cell request, valid 0..8
computer_position  in  4  computer cell request, valid 0..8
illegal_move  in  1  from illegal-move detector, combinational, valid in strobe cycle
win  in  1  from winner detector
no_space  in  1  from no-space detector
player_play  out  1  one-cycle commit strobe, player move
computer_play  out  1  one-cycle commit strobe, computer move
move_position  out  4  cell being committed, valid while a strobe is high
turn  out  2  01 player, 10 computer, 00 game over
seconds_left  out  SEC_W  remaining seconds in current turn
time_out  out  1  one-cycle pulse when a turn expires
illegal_flag  out  1  one-cycle pulse on rejected move
game_over  out  1  level, high in S_OVER

Behaviour:
- Reset (async assert, sync release): state S_PLAYER; turn=01; seconds_left=TURN_SECONDS; all strobes/pulses 0; move_position=0; prescaler=0.
- Rising-edge detect on play and pc using registered previous values; both previous values reset to 0.
- S_PLAYER: rising edge of play:
  - player_position<=8: player_play=1 for one cycle, move_position=player_position. Sample illegal_move in the same cycle.
    - illegal_move=1: illegal_flag pulse; stay in S_PLAYER; timer continues.
    - illegal_move=0: go to S_P_CHECK.
  - player_position>8: no strobe; illegal_flag pulse; stay in S_PLAYER.
  - pc edges are ignored in this state.
- S_P_CHECK (one cycle, so registers update): win or no_space -> S_OVER; else -> S_COMPUTER and restart the timer.
- S_COMPUTER / S_C_CHECK: mirror of S_PLAYER / S_P_CHECK using pc, computer_position and computer_play.
- S_OVER: turn=00; game_over=1; timer frozen; all buttons ignored until reset.
- Timer:
  - Prescaler counts 0..CLK_HZ-1 in S_PLAYER and S_COMPUTER only.
  - At terminal count, seconds_left decrements.
  - When seconds_left is 1 and terminal count occurs: time_out pulse, turn passes to the opponent state, seconds_left reloads TURN_SECONDS, prescaler=0.
  - Reload and prescaler clear also happen on every S_*_CHECK -> opponent transition.
- A button edge in the same cycle as expiry takes priority: the move commits and no time_out is issued.
- At most one commit strobe is high in any cycle; the two strobes are never high together.
- Latency: button edge to strobe is 1 cycle (registered outputs); strobe to turn change is 2 cycles.

Optional Feature:
TURN_TIMEOUT_EN
- Defined: countdown and timeout behaviour exactly as above.
- Undefined: no prescaler logic; seconds_left is held at TURN_SECONDS; time_out is tied 0; a turn lasts until a legal move is made.

Decomposition:
- Package tic_tac_toe_pkg holds:
  - state enum: S_PLAYER, S_P_CHECK, S_COMPUTER, S_C_CHECK, S_OVER.
  - turn encodings: TURN_PLAYER=2'b01, TURN_PC=2'b10, TURN_NONE=2'b00.
  - MAX_CELL=4'd8.
- One sub-module, turn_timer: prescaler plus seconds down-counter, with inputs run/reload and outputs seconds_left/expire. Instantiated only under TURN_TIMEOUT_EN.

Test Plan:
All scenarios use CLK_HZ=4, TURN_SECONDS=3.
- Reset low then high -> turn=01, seconds_left=3, all strobes 0; assert reset mid-S_COMPUTER -> immediate return to these values.
- play edge with player_position=4, illegal_move=0 -> player_play high 1 cycle, move_position=4; turn=10 two cycles later; seconds_left=3.
- play edge with player_position=4, illegal_move=1 -> illegal_flag pulse, turn stays 01; player_position=9 -> no strobe, illegal_flag pulse.
- No button for 12 cycles in S_PLAYER -> seconds_left 3,2,1, then time_out pulse, turn=10, seconds_left=3; with TURN_TIMEOUT_EN undefined -> turn stays 01 indefinitely.
- Computer commit with win=1 in S_C_CHECK -> turn=00, game_over=1; further play/pc edges produce no strobes.
- play edge in the exact expiry cycle -> player_play strobe, no time_out; pc edge during S_PLAYER -> ignored.
